// File: rtl/prim_sched_pkg.sv
// prim_sched_pkg: shared state encoding and record/opcode constants for prim_sched
package prim_sched_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FINISH} state_t;
  localparam int RECORD_WORDS = 4;
  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] NOP_OPCODE = 4'h0;
  // opcode field sits in the top OPCODE_WIDTH bits of record word 0
  function automatic int opcode_lsb(input int data_width);
    return data_width - OPCODE_WIDTH;
  endfunction
endpackage

// File: rtl/prim_sched.sv
// prim_sched: walks a list of 4-word primitive records in RAM and hands them to the raster engine
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               begin a list (IDLE only) / stop the running list
//   base_addr, prim_count      first record address (bits [1:0] ignored), number of records
//   host_we/addr/data, host_ack host RAM-load request, granted only while IDLE
//   ram_we/wr_addr/wr_data     RAM write port (host pass-through)
//   ram_read_addr, ram_rd0..3  registered read base and the four words found there
//   prim_valid/ready, prim_w0..3 record handshake towards the raster engine
//   busy, done                 list in progress, one-cycle completion pulse
// Build option: define PRIM_SCHED_SKIP_NOP_EN to skip records whose opcode is NOP.
module prim_sched
  import prim_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] prim_count,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ack,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd0,
  input  logic [DATA_WIDTH-1:0] ram_rd1,
  input  logic [DATA_WIDTH-1:0] ram_rd2,
  input  logic [DATA_WIDTH-1:0] ram_rd3,
  output logic                  prim_valid,
  input  logic                  prim_ready,
  output logic [DATA_WIDTH-1:0] prim_w0,
  output logic [DATA_WIDTH-1:0] prim_w1,
  output logic [DATA_WIDTH-1:0] prim_w2,
  output logic [DATA_WIDTH-1:0] prim_w3,
  output logic                  busy,
  output logic                  done
);
  state_t r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cur_addr, w_cur_addr_nx, r_remaining, w_remaining_nx;
  logic [ADDR_WIDTH-1:0] w_addr_inc, w_rem_dec;
  logic [3:0][DATA_WIDTH-1:0] r_rec, w_rec_nx;
  logic r_valid, w_valid_nx, w_last, w_nop;
`ifdef PRIM_SCHED_SKIP_NOP_EN
  assign w_nop = ram_rd0[opcode_lsb(DATA_WIDTH) +: OPCODE_WIDTH] == NOP_OPCODE;
`else
  assign w_nop = 1'b0;
`endif
  assign w_last = r_remaining == ADDR_WIDTH'(1);
  assign w_addr_inc = r_cur_addr + ADDR_WIDTH'(RECORD_WORDS);
  assign w_rem_dec = r_remaining - ADDR_WIDTH'(1);
  always_comb begin
    w_state_nx = r_state;
    w_cur_addr_nx = r_cur_addr;
    w_remaining_nx = r_remaining;
    w_rec_nx = r_rec;
    w_valid_nx = r_valid;
    case (r_state)
      IDLE: if (start) begin
        w_cur_addr_nx = {base_addr[ADDR_WIDTH-1:2], 2'b00};
        w_remaining_nx = prim_count;
        w_state_nx = (prim_count == '0) ? FINISH : FETCH;
      end
      FETCH: if (abort) begin
        w_state_nx = FINISH;
      end else if (w_nop) begin
        w_remaining_nx = w_rem_dec;
        w_cur_addr_nx = w_addr_inc;
        w_state_nx = w_last ? FINISH : FETCH;
      end else begin
        w_rec_nx = {ram_rd3, ram_rd2, ram_rd1, ram_rd0};
        w_valid_nx = 1'b1;
        w_state_nx = ISSUE;
      end
      ISSUE: if (abort) begin
        w_valid_nx = 1'b0;
        w_state_nx = FINISH;
      end else if (prim_ready) begin
        w_valid_nx = 1'b0;
        w_remaining_nx = w_rem_dec;
        w_cur_addr_nx = w_addr_inc;
        w_state_nx = w_last ? FINISH : FETCH;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cur_addr <= '0;
      r_remaining <= '0;
      r_rec <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cur_addr <= w_cur_addr_nx;
      r_remaining <= w_remaining_nx;
      r_rec <= w_rec_nx;
      r_valid <= w_valid_nx;
    end
  end
  // host writes only while IDLE so a record cannot change under a running list
  assign ram_we = host_we && r_state == IDLE;
  assign host_ack = ram_we;
  assign ram_wr_addr = host_addr;
  assign ram_wr_data = host_data;
  assign ram_read_addr = r_cur_addr;
  assign prim_valid = r_valid;
  assign {prim_w3, prim_w2, prim_w1, prim_w0} = r_rec;
  assign busy = r_state != IDLE;
  assign done = r_state == FINISH;
endmodule

// File: tb/tb_prim_sched.sv
// tb_prim_sched: directed self-checking bench for prim_sched with a behavioural 4-read RAM
module tb_prim_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] base_addr = '0, prim_count = '0, host_addr = '0;
  logic host_we = 1'b0, prim_ready = 1'b0;
  logic [31:0] host_data = '0;
  logic host_ack, ram_we, prim_valid, busy, done;
  logic [7:0] ram_wr_addr, ram_read_addr;
  logic [31:0] ram_wr_data, ram_rd0, ram_rd1, ram_rd2, ram_rd3;
  logic [31:0] prim_w0, prim_w1, prim_w2, prim_w3, held_w0;
  logic [31:0] mem [256];
  int n_tests = 0, n_fail = 0;

  prim_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .prim_count(prim_count),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_read_addr(ram_read_addr),
    .ram_rd0(ram_rd0), .ram_rd1(ram_rd1), .ram_rd2(ram_rd2), .ram_rd3(ram_rd3),
    .prim_valid(prim_valid), .prim_ready(prim_ready),
    .prim_w0(prim_w0), .prim_w1(prim_w1), .prim_w2(prim_w2), .prim_w3(prim_w3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM: word i holds 0x1000_0000|i after reset; written through the DUT write port
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
    else if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd0 = mem[ram_read_addr];
  assign ram_rd1 = mem[8'(ram_read_addr + 8'd1)];
  assign ram_rd2 = mem[8'(ram_read_addr + 8'd2)];
  assign ram_rd3 = mem[8'(ram_read_addr + 8'd3)];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step; step;
    chk("rst_busy", busy, 0); chk("rst_valid", prim_valid, 0); chk("rst_done", done, 0);
    chk("rst_raddr", ram_read_addr, 0); chk("rst_w0", prim_w0, 0);
    rst_n = 1'b1;
    step;
    // three records from address 8, ready tied high
    base_addr = 8'd8; prim_count = 8'd3; prim_ready = 1'b1; start = 1'b1;
    step; start = 1'b0;
    chk("l3_c1_busy", busy, 1); chk("l3_c1_raddr", ram_read_addr, 8'h08); chk("l3_c1_valid", prim_valid, 0);
    step;
    chk("l3_c2_valid", prim_valid, 1); chk("l3_c2_w0", prim_w0, 32'h1000_0008); chk("l3_c2_w3", prim_w3, 32'h1000_000B);
    step;
    chk("l3_c3_valid", prim_valid, 0); chk("l3_c3_raddr", ram_read_addr, 8'h0C);
    step;
    chk("l3_c4_valid", prim_valid, 1); chk("l3_c4_w0", prim_w0, 32'h1000_000C);
    step;
    chk("l3_c5_raddr", ram_read_addr, 8'h10);
    step;
    chk("l3_c6_valid", prim_valid, 1); chk("l3_c6_w1", prim_w1, 32'h1000_0011); chk("l3_c6_done", done, 0);
    step;
    chk("l3_c7_done", done, 1); chk("l3_c7_valid", prim_valid, 0);
    step;
    chk("l3_c8_done", done, 0); chk("l3_c8_busy", busy, 0);
    // backpressure: ready low for 5 cycles
    base_addr = 8'h20; prim_count = 8'd1; prim_ready = 1'b0; start = 1'b1;
    step; start = 1'b0;
    step;
    chk("bp_valid", prim_valid, 1); chk("bp_w0", prim_w0, 32'h1000_0020);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("bp_hold_valid", prim_valid, 1); chk("bp_hold_w0", prim_w0, 32'h1000_0020);
      chk("bp_hold_w2", prim_w2, 32'h1000_0022); chk("bp_hold_raddr", ram_read_addr, 8'h20);
    end
    prim_ready = 1'b1;
    step;
    chk("bp_rel_valid", prim_valid, 0); chk("bp_rel_done", done, 1);
    step;
    chk("bp_idle", busy, 0);
    // empty list
    prim_count = 8'd0; start = 1'b1;
    step; start = 1'b0;
    chk("z_done", done, 1); chk("z_valid", prim_valid, 0); chk("z_busy", busy, 1);
    step;
    chk("z_done_clr", done, 0); chk("z_idle", busy, 0); chk("z_valid2", prim_valid, 0);
    // start and host write together, then a host write while busy
    base_addr = 8'h04; prim_count = 8'd1; start = 1'b1;
    host_we = 1'b1; host_addr = 8'h05; host_data = 32'hDEAD_BEEF;
    #1;
    chk("hw_we", ram_we, 1); chk("hw_ack", host_ack, 1);
    chk("hw_addr", ram_wr_addr, 8'h05); chk("hw_data", ram_wr_data, 32'hDEAD_BEEF);
    step; start = 1'b0;
    host_addr = 8'h06; host_data = 32'h1234_5678;
    #1;
    chk("hb_ack", host_ack, 0); chk("hb_we", ram_we, 0);
    step; host_we = 1'b0;
    chk("hw_fetch_w1", prim_w1, 32'hDEAD_BEEF); chk("hw_fetch_w0", prim_w0, 32'h1000_0004);
    step; step;
    start = 1'b1;
    step; start = 1'b0;
    step;
    chk("hb_unchanged_w2", prim_w2, 32'h1000_0006);
    step; step;
    // address wrap and base alignment
    base_addr = 8'hFC; prim_count = 8'd2; start = 1'b1;
    step; start = 1'b0;
    chk("wr_raddr1", ram_read_addr, 8'hFC);
    step;
    chk("wr_w3", prim_w3, 32'h1000_00FF);
    step;
    chk("wr_raddr2", ram_read_addr, 8'h00);
    step;
    chk("wr_w0", prim_w0, 32'h1000_0000);
    step; step;
    base_addr = 8'h0B; prim_count = 8'd1; start = 1'b1;
    step; start = 1'b0;
    chk("al_raddr", ram_read_addr, 8'h08);
    step;
    chk("al_w0", prim_w0, 32'h1000_0008);
    step; step;
    // abort in ISSUE, and abort in IDLE
    base_addr = 8'h10; prim_count = 8'd3; prim_ready = 1'b0; start = 1'b1;
    step; start = 1'b0;
    step;
    chk("ab_valid", prim_valid, 1);
    abort = 1'b1;
    step; abort = 1'b0;
    chk("ab_valid_drop", prim_valid, 0); chk("ab_done", done, 1);
    step;
    chk("ab_done_once", done, 0); chk("ab_idle", busy, 0);
    abort = 1'b1;
    step; abort = 1'b0;
    chk("ab_idle_noeffect", busy, 0);
    // a record with NOP opcode at 0x40 followed by a normal one at 0x44
    host_we = 1'b1; host_addr = 8'h40; host_data = 32'h0000_0ABC;
    step; host_we = 1'b0;
    base_addr = 8'h40; prim_count = 8'd2; prim_ready = 1'b1; start = 1'b1;
    step; start = 1'b0;
    step;
`ifdef PRIM_SCHED_SKIP_NOP_EN
    chk("nop_skip_valid", prim_valid, 0); chk("nop_raddr", ram_read_addr, 8'h44);
    step;
    chk("nop_next_valid", prim_valid, 1); chk("nop_next_w0", prim_w0, 32'h1000_0044);
    step;
    chk("nop_done", done, 1);
`else
    chk("nop_issue_valid", prim_valid, 1); chk("nop_issue_w0", prim_w0, 32'h0000_0ABC);
    step; step;
    chk("nop_second_w0", prim_w0, 32'h1000_0044);
    step;
    chk("nop_done", done, 1);
`endif
    step;
    chk("nop_idle", busy, 0);
    // reset in the middle of a list
    base_addr = 8'h08; prim_count = 8'd3; prim_ready = 1'b0; start = 1'b1;
    step; start = 1'b0;
    step;
    chk("mr_valid", prim_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid_clr", prim_valid, 0); chk("mr_busy", busy, 0);
    chk("mr_raddr", ram_read_addr, 0); chk("mr_w0", prim_w0, 0);
    step;
    rst_n = 1'b1;
    step;
    chk("mr_no_done", done, 0); chk("mr_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
